systolic_output_deskew_fifo: RTL and testbench

- Sits directly downstream of the weight-stationary systolic array top. Consumes its per-column result stream, where column c of a result row arrives c cycles after column 0.
- Re-aligns (deskews) the columns into one full row vector and buffers rows in a first-word-fall-through FIFO.
- Presents rows to the writeback/AXI side with a valid/ready handshake.
- The array has no backpressure, so FIFO overflow drops the row and raises a sticky error flag.

---
 rtl/systolic_output_deskew_fifo_if.sv | 25 ++
 rtl/systolic_output_deskew_fifo.sv | 127 ++++++++++++
 tb/tb_systolic_output_deskew_fifo.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_output_deskew_fifo_if.sv
// Row-result bus between the systolic array, the deskew FIFO and the writeback side.
// The master drives the skewed column stream and the ready; the slave (FIFO) returns rows and status.
interface systolic_output_deskew_fifo_if #(
  parameter int NUM_COL        = 8,
  parameter int OUT_DATA_WIDTH = 23
);
  logic [NUM_COL*OUT_DATA_WIDTH-1:0] i_data;
  logic [NUM_COL-1:0]                i_valid;
  logic [NUM_COL*OUT_DATA_WIDTH-1:0] o_data;
  logic                              o_valid;
  logic                              i_ready;
  logic [15:0]                       o_row_cnt;
  logic                              o_overflow;
  logic                              o_misalign;

  modport master (
    output i_data, i_valid, i_ready,
    input  o_data, o_valid, o_row_cnt, o_overflow, o_misalign
  );

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_data, o_valid, o_row_cnt, o_overflow, o_misalign
  );
endinterface

// File: rtl/systolic_output_deskew_fifo.sv
// Deskews the per-column systolic result stream into full rows and buffers them in a
// first-word-fall-through FIFO. The array cannot stall, so a full FIFO drops rows.
module systolic_output_deskew_fifo #(
  parameter int NUM_ROW        = 8,
  parameter int NUM_COL        = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int OUT_DATA_WIDTH = (DATA_WIDTH << 1) + NUM_ROW - 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  systolic_output_deskew_fifo_if.slave  bus
);

  localparam int ROW_W = NUM_COL * OUT_DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [OUT_DATA_WIDTH-1:0] a_data [NUM_COL];
  logic [NUM_COL-1:0]        a_valid;
  logic [ROW_W-1:0]          a_row;

  // Lane c waits NUM_COL-1-c cycles so every lane lines up with the last column.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_lane
    localparam int D = NUM_COL - 1 - c;
    if (D == 0) begin : g_direct
      assign a_data[c]  = bus.i_data[c*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
      assign a_valid[c] = bus.i_valid[c];
    end else begin : g_delay
      logic [OUT_DATA_WIDTH-1:0] dly_data_q [D];
      logic [D-1:0]              dly_vld_q;

      always_ff @(posedge clk) begin
        if (rst_n) begin
          for (int unsigned i = 0; i < D; i++) begin
            dly_data_q[i] <= '0;
          end
          dly_vld_q <= '0;
        end else begin
          dly_data_q[0] <= bus.i_data[c*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
          dly_vld_q[0]  <= bus.i_valid[c];
          for (int unsigned i = 1; i < D; i++) begin
            dly_data_q[i] <= dly_data_q[i-1];
            dly_vld_q[i]  <= dly_vld_q[i-1];
          end
        end
      end

      assign a_data[c]  = dly_data_q[D-1];
      assign a_valid[c] = dly_vld_q[D-1];
    end
  end

  always_comb begin
    a_row = '0;
    for (int unsigned c = 0; c < NUM_COL; c++) begin
      a_row[c*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = a_data[c];
    end
  end

  logic [ROW_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      row_cnt_q, row_cnt_d;
  logic             ovf_q, ovf_d;
  logic             mis_q, mis_d;
  logic             push_req, push, pop, full, empty;

  // A full FIFO still takes a row when the head leaves in the same cycle.
  always_comb begin
    push_req  = &a_valid;
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    empty     = (count_q == '0);
    pop       = !empty && bus.i_ready;
    push      = push_req && (!full || pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    row_cnt_d = row_cnt_q;
    ovf_d     = ovf_q | (push_req & full & !pop);
    mis_d     = mis_q | ((|a_valid) & !push_req);
    if (push) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      row_cnt_d = row_cnt_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      row_cnt_q <= '0;
      ovf_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= a_row;
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      row_cnt_q <= row_cnt_d;
      ovf_q     <= ovf_d;
      mis_q     <= mis_d;
    end
  end

  assign bus.o_data     = mem_q[rd_ptr_q];
  assign bus.o_valid    = !empty;
  assign bus.o_row_cnt  = row_cnt_q;
  assign bus.o_overflow = ovf_q;
  assign bus.o_misalign = mis_q;

endmodule

// File: tb/tb_systolic_output_deskew_fifo.sv
// Directed bench for the deskew FIFO: per-cycle vector table for deskew/streaming,
// hand sequences for full+pop, misalignment, overflow and mid-stream reset.
module tb_systolic_output_deskew_fifo;

  localparam int NC = 4;
  localparam int W  = (8 << 1) + 4 - 1;
  localparam int RW = NC * W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  systolic_output_deskew_fifo_if #(.NUM_COL(NC), .OUT_DATA_WIDTH(W)) bus ();

  systolic_output_deskew_fifo #(
    .NUM_ROW(4), .NUM_COL(NC), .DATA_WIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic          rst;
    logic [NC-1:0] v;
    logic [RW-1:0] d;
    logic          rdy;
    logic          chk;
    logic          ev;
    logic [RW-1:0] ed;
    logic [15:0]   cnt;
    logic          ovf;
    logic          mis;
  } vec_t;

  vec_t          tbl[$];
  logic [RW-1:0] got[$];
  int            total  = 0;
  int            passed = 0;

  always @(negedge clk) begin
    if (!rst_n && bus.o_valid && bus.i_ready) got.push_back(bus.o_data);
  end

  function automatic logic [RW-1:0] pack4(int unsigned a, int unsigned b, int unsigned c, int unsigned d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic logic [RW-1:0] rowv(int unsigned base, int r);
    int unsigned b;
    b = base + 16 * r;
    return pack4(b, b + 1, b + 2, b + 3);
  endfunction

  function automatic void add(logic rst, logic [NC-1:0] v, logic [RW-1:0] d, logic rdy, logic chk,
                              logic ev, logic [RW-1:0] ed, int cnt, logic ovf, logic mis);
    vec_t t;
    t.rst = rst; t.v = v; t.d = d; t.rdy = rdy; t.chk = chk;
    t.ev = ev; t.ed = ed; t.cnt = 16'(cnt); t.ovf = ovf; t.mis = mis;
    tbl.push_back(t);
  endfunction

  task automatic chk(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic idle_inputs();
    bus.i_valid = '0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b0;
    got.delete();
  endtask

  // Rows start on consecutive cycles; row r lane c is presented in cycle r+c.
  task automatic drive_rows(int unsigned base, int nrows, logic [31:0] rdy_mask, int drop_row, int ncycles);
    logic [NC-1:0] v;
    logic [RW-1:0] d;
    int            r;
    for (int k = 0; k < ncycles; k++) begin
      v = '0;
      d = '0;
      for (int c = 0; c < NC; c++) begin
        r = k - c;
        if (r >= 0 && r < nrows && !(r == drop_row && c == 2)) begin
          v[c] = 1'b1;
          d[c*W +: W] = W'(base + 16 * r + c);
        end
      end
      bus.i_valid = v;
      bus.i_data  = d;
      bus.i_ready = rdy_mask[k];
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic drain(int n);
    bus.i_ready = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b0;
  endtask

  task automatic chk_rows(string name, int unsigned base, int n, int stride);
    chk({name, "_count"}, RW'(got.size()), RW'(n));
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) chk($sformatf("%s_row%0d", name, i), got[i], rowv(base, i * stride));
    end
  endtask

  initial begin
    vec_t          t;
    logic [NC-1:0] v;
    logic [RW-1:0] d;
    int            r;
    int            stale;

    rst_n = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Single-row deskew: lane c valid only in cycle c.
    add(1, 4'b0000, '0, 1, 0, 0, '0, 0, 0, 0);
    add(0, 4'b0001, pack4(32'h100, 0, 0, 0), 1, 1, 0, '0, 0, 0, 0);
    add(0, 4'b0010, pack4(0, 32'h101, 0, 0), 1, 1, 0, '0, 0, 0, 0);
    add(0, 4'b0100, pack4(0, 0, 32'h102, 0), 1, 1, 0, '0, 0, 0, 0);
    add(0, 4'b1000, pack4(0, 0, 0, 32'h103), 1, 1, 0, '0, 0, 0, 0);
    add(0, 4'b0000, '0, 1, 1, 1, pack4(32'h100, 32'h101, 32'h102, 32'h103), 1, 0, 0);
    add(0, 4'b0000, '0, 1, 1, 0, '0, 1, 0, 0);
    add(0, 4'b0000, '0, 1, 1, 0, '0, 1, 0, 0);

    // Eight back-to-back rows, row r lane c = 16*r+c; rows emerge in cycles 4..11.
    add(1, 4'b0000, '0, 1, 0, 0, '0, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      v = '0;
      d = '0;
      for (int c = 0; c < NC; c++) begin
        r = k - c;
        if (r >= 0 && r < 8) begin
          v[c] = 1'b1;
          d[c*W +: W] = W'(16 * r + c);
        end
      end
      add(0, v, d, 1, 1, (k >= 4 && k < 12), (k >= 4 && k < 12) ? rowv(0, k - 4) : '0,
          (k < 4) ? 0 : ((k - 3 > 8) ? 8 : k - 3), 0, 0);
    end

    foreach (tbl[i]) begin
      t = tbl[i];
      rst_n       = t.rst;
      bus.i_valid = t.v;
      bus.i_data  = t.d;
      bus.i_ready = t.rdy;
      @(negedge clk);
      if (t.chk) begin
        chk($sformatf("v%0d_valid", i), RW'(bus.o_valid), RW'(t.ev));
        if (t.ev) chk($sformatf("v%0d_data", i), bus.o_data, t.ed);
        chk($sformatf("v%0d_nox", i), RW'($isunknown(bus.o_data)), '0);
        chk($sformatf("v%0d_rowcnt", i), RW'(bus.o_row_cnt), RW'(t.cnt));
        chk($sformatf("v%0d_ovf", i), RW'(bus.o_overflow), RW'(t.ovf));
        chk($sformatf("v%0d_mis", i), RW'(bus.o_misalign), RW'(t.mis));
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    idle_inputs();

    // Full FIFO with a pop in the same cycle as the fifth row's push.
    do_reset();
    drive_rows(32'h300, 5, 32'h0000_0080, -1, 8);
    chk("fullpop_valid", RW'(bus.o_valid), RW'(1));
    chk("fullpop_head", bus.o_data, rowv(32'h300, 1));
    chk("fullpop_rowcnt", RW'(bus.o_row_cnt), RW'(5));
    chk("fullpop_ovf", RW'(bus.o_overflow), '0);
    drain(6);
    chk_rows("fullpop", 32'h300, 5, 1);
    chk("fullpop_empty", RW'(bus.o_valid), '0);

    // Lane 2 missing on row 1: row dropped, sticky misalign, rows 0 and 2 kept.
    do_reset();
    drive_rows(32'h400, 3, 32'hFFFF_FFFF, 1, 8);
    chk_rows("mis", 32'h400, 2, 2);
    chk("mis_flag", RW'(bus.o_misalign), RW'(1));
    chk("mis_rowcnt", RW'(bus.o_row_cnt), RW'(2));
    chk("mis_ovf", RW'(bus.o_overflow), '0);

    // Six rows into a stalled 4-entry FIFO; misalign stays sticky from before.
    got.delete();
    drive_rows(32'h500, 6, 32'h0, -1, 10);
    chk("ovf_valid", RW'(bus.o_valid), RW'(1));
    chk("ovf_head", bus.o_data, rowv(32'h500, 0));
    chk("ovf_rowcnt", RW'(bus.o_row_cnt), RW'(6));
    chk("ovf_flag", RW'(bus.o_overflow), RW'(1));
    chk("ovf_mis_sticky", RW'(bus.o_misalign), RW'(1));
    @(posedge clk); #1;
    chk("ovf_head_hold", bus.o_data, rowv(32'h500, 0));
    drain(6);
    chk_rows("ovf", 32'h500, 4, 1);
    chk("ovf_empty", RW'(bus.o_valid), '0);

    // Reset with three rows buffered and two still in the delay lines.
    got.delete();
    drive_rows(32'h600, 5, 32'h0, -1, 6);
    chk("rst_pre_valid", RW'(bus.o_valid), RW'(1));
    chk("rst_pre_rowcnt", RW'(bus.o_row_cnt), RW'(9));
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    chk("rst_valid", RW'(bus.o_valid), '0);
    chk("rst_data", bus.o_data, '0);
    chk("rst_rowcnt", RW'(bus.o_row_cnt), '0);
    chk("rst_ovf", RW'(bus.o_overflow), '0);
    chk("rst_mis", RW'(bus.o_misalign), '0);
    stale = 0;
    bus.i_ready = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.o_valid) stale++;
    end
    bus.i_ready = 1'b0;
    chk("rst_no_stale", RW'(stale), '0);
    chk("rst_no_pops", RW'(got.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
